// File: rtl/xalu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xalu_defs (package)
// Purpose  : XALUOp encodings, default latencies, FSM state type and decode
//            helpers shared by the XALU, the decoder and the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package xalu_defs;

  localparam logic [3:0] XALU_NONE  = 4'd0;
  localparam logic [3:0] XALU_MULT  = 4'd1;
  localparam logic [3:0] XALU_MULTU = 4'd2;
  localparam logic [3:0] XALU_DIV   = 4'd3;
  localparam logic [3:0] XALU_DIVU  = 4'd4;
  localparam logic [3:0] XALU_MTHI  = 4'd5;
  localparam logic [3:0] XALU_MTLO  = 4'd6;
  localparam logic [3:0] XALU_MFHI  = 4'd7;
  localparam logic [3:0] XALU_MFLO  = 4'd8;

  localparam int XALU_MULT_CYCLES = 5;
  localparam int XALU_DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    XALU_IDLE = 1'b0,
    XALU_RUN  = 1'b1
  } xalu_state_t;

  // True for the four multi-cycle ops (mult/multu/div/divu)
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == XALU_MULT) || (op == XALU_MULTU) ||
           (op == XALU_DIV)  || (op == XALU_DIVU);
  endfunction

  // True for the multiply subset, used to select the latency
  function automatic logic is_mult(input logic [3:0] op);
    return (op == XALU_MULT) || (op == XALU_MULTU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xalu_if.sv
`default_nettype none
// ============================================================================
// Module   : xalu_if
// Purpose  : E-stage request / result bundle between pipeline and XALU.
//            master = pipeline side, slave = XALU side.
// Revision : 1.0 - initial release
// ============================================================================
interface xalu_if;
  logic [3:0]  XALUOp_E;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] XALUOut;

  modport master (
    output XALUOp_E, A, B, Cancel,
    input  Busy, HI, LO, XALUOut
  );

  modport slave (
    input  XALUOp_E, A, B, Cancel,
    output Busy, HI, LO, XALUOut
  );
endinterface
`default_nettype wire

// File: rtl/xalu_calc.sv
`default_nettype none
// ============================================================================
// Module   : xalu_calc
// Purpose  : Purely combinational mult/multu/div/divu datapath. Produces the
//            64-bit {hi,lo} result and a divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module xalu_calc
  import xalu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  // Signed divide is done on magnitudes with one shared unsigned divider.
  // |0x80000000| is 0x80000000 as an unsigned value, so the overflow case
  // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_dvsr;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_signed_div = (op == XALU_DIV);
  assign w_a_neg      = w_signed_div & a[31];
  assign w_b_neg      = w_signed_div & b[31];
  assign w_ua         = w_a_neg ? (~a + 32'd1) : a;
  assign w_ub         = w_b_neg ? (~b + 32'd1) : b;
  // Keep the divider X-free when B is zero; the result is discarded anyway
  assign w_dvsr       = (b == 32'd0) ? 32'd1 : w_ub;
  assign w_q          = w_ua / w_dvsr;
  assign w_r          = w_ua % w_dvsr;

  // Low 64 bits of a product of sign-extended operands equal the signed product
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  assign div0 = ((op == XALU_DIV) || (op == XALU_DIVU)) && (b == 32'd0);

  // Select the result for the requested op; remainder follows dividend sign
  always_comb begin
    result = 64'd0;
    case (op)
      XALU_MULT:  result = w_prod_s;
      XALU_MULTU: result = w_prod_u;
      XALU_DIV:   result = {(w_a_neg ? (~w_r + 32'd1) : w_r),
                            ((w_a_neg ^ w_b_neg) ? (~w_q + 32'd1) : w_q)};
      XALU_DIVU:  result = {w_r, w_q};
      default:    result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/xalu.sv
`default_nettype none
// ============================================================================
// Module   : xalu
// Purpose  : EX-stage multiply/divide unit: start/run FSM, latency counter,
//            shadow result registers and the architectural HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module xalu
  import xalu_defs::*;
#(
  parameter int MULT_CYCLES = XALU_MULT_CYCLES,
  parameter int DIV_CYCLES  = XALU_DIV_CYCLES
)(
  input  logic    clk,
  input  logic    reset,
  xalu_if.slave   bus
);

  localparam int CNT_W = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  xalu_state_t      r_state;
  xalu_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_s;
  logic [31:0]      r_lo_s;

  logic             w_start;
  logic [CNT_W-1:0] w_load;
  logic [63:0]      w_result;
  logic             w_div0;
  logic [63:0]      w_shadow;

  xalu_calc u_calc (
    .op     (bus.XALUOp_E),
    .a      (bus.A),
    .b      (bus.B),
    .result (w_result),
    .div0   (w_div0)
  );

  assign w_start = (r_state == XALU_IDLE) && is_muldiv(bus.XALUOp_E) && !bus.Cancel;
  assign w_load  = is_mult(bus.XALUOp_E) ? C_MULT_LOAD : C_DIV_LOAD;
  // Divide by zero latches the current HI/LO so the commit leaves them as-is
  assign w_shadow = w_div0 ? {r_hi, r_lo} : w_result;

  assign bus.Busy    = (r_state == XALU_RUN) | w_start;
  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;
  assign bus.XALUOut = (bus.XALUOp_E == XALU_MFHI) ? r_hi :
                       (bus.XALUOp_E == XALU_MFLO) ? r_lo : 32'd0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= XALU_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: a single-cycle latency commits at the start edge and skips RUN
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      XALU_IDLE: if (w_start && (w_load != '0)) w_state_next = XALU_RUN;
      XALU_RUN:  if (r_cnt == CNT_W'(1))        w_state_next = XALU_IDLE;
      default:   w_state_next = XALU_IDLE;
    endcase
  end

  // Counter, shadow capture, commit and mthi/mtlo writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_hi_s <= 32'd0;
      r_lo_s <= 32'd0;
    end else if (w_start) begin
      r_hi_s <= w_shadow[63:32];
      r_lo_s <= w_shadow[31:0];
      r_cnt  <= w_load;
      if (w_load == '0) begin
        r_hi <= w_shadow[63:32];
        r_lo <= w_shadow[31:0];
      end
    end else if (r_state == XALU_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_hi <= r_hi_s;
        r_lo <= r_lo_s;
      end
    end else if (!bus.Cancel) begin
      if (bus.XALUOp_E == XALU_MTHI) r_hi <= bus.A;
      if (bus.XALUOp_E == XALU_MTLO) r_lo <= bus.A;
    end
  end

endmodule
`default_nettype wire

// File: doc/xalu.md
Name: xalu

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with multi-cycle latency, plus mthi/mtlo writes and mfhi/mflo reads of the architectural HI/LO registers.
- Drives Busy to the D-stage hazard/stall unit, which stalls any D-stage XALU instruction (XALUOp_D != 0) while Busy is high.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high after a mult/multu start.
- DIV_CYCLES, 10, number of cycles Busy stays high after a div/divu start.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- XALUOp_E  input  4  op of the instruction in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
- A  input  32  forwarded rs value in E.
- B  input  32  forwarded rt value in E.
- Cancel  input  1  E instruction is being flushed (exception/interrupt); suppresses any start or HI/LO write this cycle.
- Busy  output  1  to the hazard unit; high while an operation is in progress, including its start cycle.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.
- XALUOut  output  32  mfhi returns HI, mflo returns LO, all other ops return 0; combinational.

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, state=IDLE, cnt=0, shadow regs=0, Busy=0.
- State machine has two states.
  - IDLE: start = (op in 1..4) && !Cancel.
  - On start:
    - Latch the result into shadow HI_s/LO_s at the clock edge.
    - Load cnt = MULT_CYCLES-1 for mult/multu, DIV_CYCLES-1 for div/divu.
    - Go to RUN.
  - RUN: cnt decrements each cycle. When cnt==1 at a clock edge, commit HI<=HI_s, LO<=LO_s and go to IDLE.
  - With MULT_CYCLES=1, commit happens at the start edge; RUN is skipped.
- Busy = (state==RUN) | start.
  - Busy is combinational in the start cycle, so the following D instruction stalls immediately.
  - Total Busy-high cycles = MULT_CYCLES or DIV_CYCLES exactly.
  - HI/LO show the new values the first cycle Busy is low.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div special case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B==0): full DIV_CYCLES latency; HI/LO remain unchanged at commit.
- mthi/mtlo (IDLE, !Cancel): HI<=A or LO<=A at the next edge, single cycle, Busy stays 0.
- Any XALU op arriving in E while in RUN is ignored. Stall logic prevents this; the bench flags it as an assertion error.
- mfhi/mflo during RUN return the old committed values; the stall logic prevents this case in normal operation.
- Cancel during RUN has no effect: an operation already started runs to completion.
- Reset asserted mid-operation aborts immediately to reset values; no commit occurs.

Decomposition:
- Shared package xalu_defs holds the XALUOp encodings (XALU_NONE..XALU_MFLO) and the default latencies. The decoder and the hazard unit use the same constants.
- One sub-module, xalu_calc: combinational and purely arithmetic. It takes op, A, B and produces a 64-bit {hi,lo} result and a div0 flag.
- The xalu top holds only the FSM, counter, shadow and committed registers.

Test Plan:
- Reset mid-op: start div 100/7, assert reset at cycle 4 -> HI=LO=0, Busy=0 at once; no later commit.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles from the start cycle; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Divide by zero: mthi 0x1234, mtlo 0x5678, then div A=5, B=0 -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- Cancel: mult A=3, B=4 with Cancel=1 -> Busy stays 0, HI/LO unchanged. Then mult A=3, B=4 with Cancel=0, and Cancel pulses at cycle 2 -> LO=12 after 5 cycles.
- mtlo A=0xDEADBEEF then mflo next cycle -> XALUOut=0xDEADBEEF, Busy never high. mfhi during RUN of mult -> returns the pre-op HI.
